// File: rtl/cdma_wr_req_split_pkg.sv
// Shared types for the CDMA write front-end: bus widths and the splitter FSM state.
package iwTypes;

  localparam int LEN_BITS      = 24;
  localparam int AXI_DATA_BITS = 512;
  localparam int AXI_ADDR_BITS = 40;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2
  } cdma_split_state_t;

endpackage

// File: rtl/cdma_wr_req_split_if.sv
// Request-side and engine-side handshake bundle of the CDMA write request splitter.
interface cdma_wr_req_split_if import iwTypes::*; #(
  parameter int ADDR_BITS = AXI_ADDR_BITS,
  parameter int LEN_BITS  = iwTypes::LEN_BITS
);

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic [LEN_BITS-1:0]  req_len;
  logic                 req_ctl;
  logic                 cmpl_done;
  logic                 busy;
  logic                 ctrl_valid;
  logic                 stat_ready;
  logic [ADDR_BITS-1:0] ctrl_addr;
  logic [LEN_BITS-1:0]  ctrl_len;
  logic                 ctrl_ctl;
  logic                 stat_done;

  modport slave (
    input  req_valid, req_addr, req_len, req_ctl, stat_ready, stat_done,
    output req_ready, cmpl_done, busy, ctrl_valid, ctrl_addr, ctrl_len, ctrl_ctl
  );

  modport master (
    output req_valid, req_addr, req_len, req_ctl, stat_ready, stat_done,
    input  req_ready, cmpl_done, busy, ctrl_valid, ctrl_addr, ctrl_len, ctrl_ctl
  );

endinterface

// File: rtl/cdma_wr_req_split_q_srl.sv
// Small synchronous FIFO holding one completion flag per outstanding sub-command.
module Q_srl import iwTypes::*; #(
  parameter int depth = 16,
  parameter int width = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [width-1:0] i_d,
  input  logic             i_v,
  output logic             i_r,
  output logic [width-1:0] o_d,
  output logic             o_v,
  input  logic             o_r
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign i_r  = (cnt_q != CW'(depth));
  assign o_v  = (cnt_q != '0);
  assign o_d  = mem_q[rd_ptr_q];
  assign push = i_v & i_r;
  assign pop  = o_r & o_v;

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= i_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cdma_wr_req_split.sv
// Splits aligned write requests into CHUNK_BYTES-bounded sub-commands with credit tracking.
// Optional counters stat_reqs/stat_chunks are built when CDMA_SPLIT_STATS_EN is defined.
//
// state   | meaning
// S_IDLE  | ready for a request
// S_CALC  | size next sub-command up to the chunk boundary
// S_ISSUE | present sub-command to engine, wait for credit + handshake
module cdma_wr_req_split import iwTypes::*; #(
  parameter int DATA_BITS       = AXI_DATA_BITS,
  parameter int ADDR_BITS       = AXI_ADDR_BITS,
  parameter int CHUNK_BYTES     = 4096,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  cdma_wr_req_split_if.slave  bus
`ifdef CDMA_SPLIT_STATS_EN
  ,
  output logic [31:0]         stat_reqs,
  output logic [31:0]         stat_chunks
`endif
);

  localparam int CW = $clog2(CHUNK_BYTES);
  localparam int RW = CW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  if ((CHUNK_BYTES < DATA_BITS / 8) || ((CHUNK_BYTES & (CHUNK_BYTES - 1)) != 0)) begin : g_cfg_err
    $error("CHUNK_BYTES must be a power of two no smaller than the data bus width in bytes");
  end

  cdma_split_state_t    state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  rem_q;
  logic                 ctl_q;
  logic                 last_q;
  logic [ADDR_BITS-1:0] ctrl_addr_q;
  logic [LEN_BITS-1:0]  ctrl_len_q;
  logic [OW-1:0]        outstanding_q;
  logic                 cmpl_q;

  logic [RW-1:0]        room;
  logic [LEN_BITS-1:0]  room_ext;
  logic [LEN_BITS-1:0]  chunk;
  logic                 last;
  logic                 req_ready_c;
  logic                 ctrl_valid_c;
  logic                 accept_c;
  logic                 credit_ok;
  logic                 issue;
  logic                 pop;
  logic                 q_i_r;
  logic                 q_o_v;
  logic [0:0]           q_o_d;

  assign room     = RW'(CHUNK_BYTES) - {1'b0, addr_q[CW-1:0]};
  assign room_ext = LEN_BITS'(room);
  assign chunk    = (rem_q < room_ext) ? rem_q : room_ext;
  assign last     = (rem_q <= room_ext);

  // Queue space and the outstanding counter both bound the credit.
  assign credit_ok = (outstanding_q < OW'(MAX_OUTSTANDING)) && q_i_r;
  assign issue     = ctrl_valid_c && bus.stat_ready;
  assign pop       = bus.stat_done && q_o_v;
  assign accept_c  = req_ready_c && bus.req_valid;

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_c  = 1'b0;
    ctrl_valid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid && (bus.req_len != '0)) state_d = S_CALC;
      end
      S_CALC: state_d = S_ISSUE;
      S_ISSUE: begin
        ctrl_valid_c = credit_ok;
        if (credit_ok && bus.stat_ready) state_d = last_q ? S_IDLE : S_CALC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q        <= '0;
      rem_q         <= '0;
      ctl_q         <= 1'b0;
      last_q        <= 1'b0;
      ctrl_addr_q   <= '0;
      ctrl_len_q    <= '0;
      outstanding_q <= '0;
      cmpl_q        <= 1'b0;
    end else begin
      if (accept_c && (bus.req_len != '0)) begin
        addr_q <= bus.req_addr;
        rem_q  <= bus.req_len;
        ctl_q  <= bus.req_ctl;
      end
      if (state_q == S_CALC) begin
        ctrl_addr_q <= addr_q;
        ctrl_len_q  <= chunk;
        last_q      <= last;
      end
      if (issue) begin
        addr_q <= addr_q + ADDR_BITS'(ctrl_len_q);
        rem_q  <= rem_q - ctrl_len_q;
      end
      case ({issue, pop})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      cmpl_q <= pop && q_o_d[0];
    end
  end

  Q_srl #(
    .depth (MAX_OUTSTANDING),
    .width (1)
  ) u_cmpl_q (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_d     (ctl_q & last_q),
    .i_v     (issue),
    .i_r     (q_i_r),
    .o_d     (q_o_d),
    .o_v     (q_o_v),
    .o_r     (bus.stat_done)
  );

  assign bus.req_ready  = req_ready_c;
  assign bus.ctrl_valid = ctrl_valid_c;
  assign bus.ctrl_addr  = ctrl_addr_q;
  assign bus.ctrl_len   = ctrl_len_q;
  assign bus.ctrl_ctl   = 1'b1;
  assign bus.cmpl_done  = cmpl_q;
  assign bus.busy       = (state_q != S_IDLE) || (outstanding_q != '0);

`ifdef CDMA_SPLIT_STATS_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_reqs   <= '0;
      stat_chunks <= '0;
    end else begin
      if (accept_c) stat_reqs   <= stat_reqs + 32'd1;
      if (issue)    stat_chunks <= stat_chunks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdma_wr_req_split.sv
// Scoreboard bench for cdma_wr_req_split: directed requests, queued expected sub-commands and completions.
module tb_cdma_wr_req_split;
  import iwTypes::*;

  localparam int AB   = AXI_ADDR_BITS;
  localparam int LB   = LEN_BITS;
  localparam int MAXO = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  cdma_wr_req_split_if #(.ADDR_BITS(AB), .LEN_BITS(LB)) bus ();

`ifdef CDMA_SPLIT_STATS_EN
  logic [31:0] stat_reqs;
  logic [31:0] stat_chunks;
`endif

  cdma_wr_req_split #(
    .DATA_BITS       (512),
    .ADDR_BITS       (AB),
    .CHUNK_BYTES     (4096),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
`ifdef CDMA_SPLIT_STATS_EN
    ,
    .stat_reqs   (stat_reqs),
    .stat_chunks (stat_chunks)
`endif
  );

  typedef struct {
    logic [AB-1:0] addr;
    logic [LB-1:0] len;
    bit            flag;
  } cmd_t;

  cmd_t exp_q[$];
  bit   flag_q[$];
  cmd_t mon_e;
  bit   cmpl_exp_next;
  int   n_tests, n_fail;
  int   n_issued, n_cmpl;
  int   eng_served, man_req, man_served;
  bit   auto_done, want_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic push_cmd(input logic [AB-1:0] a, input logic [LB-1:0] l, input bit f);
    cmd_t c;
    c.addr = a; c.len = l; c.flag = f;
    exp_q.push_back(c);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge aclk);
    #1;
  endtask

  // Monitor: compares sub-commands and completion pulses against the queued expectations.
  always @(negedge aclk) begin
    if (!aresetn) begin
      flag_q.delete();
      exp_q.delete();
      cmpl_exp_next = 1'b0;
    end else begin
      if (bus.cmpl_done || cmpl_exp_next) chk("cmpl_done", 64'(bus.cmpl_done), 64'(cmpl_exp_next));
      if (bus.cmpl_done) n_cmpl++;
      cmpl_exp_next = 1'b0;
      if (bus.stat_done && flag_q.size() > 0) cmpl_exp_next = flag_q.pop_front();
      if (bus.ctrl_valid && bus.stat_ready) begin
        n_issued++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_cmd: got addr 0x%0h len 0x%0h, want none", bus.ctrl_addr, bus.ctrl_len);
          flag_q.push_back(1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd_addr", 64'(bus.ctrl_addr), 64'(mon_e.addr));
          chk("cmd_len",  64'(bus.ctrl_len),  64'(mon_e.len));
          chk("cmd_ctl",  64'(bus.ctrl_ctl),  64'd1);
          flag_q.push_back(mon_e.flag);
        end
      end
    end
  end

  // Engine model: sole driver of stat_ready/stat_done.
  initial begin
    bus.stat_done  = 1'b0;
    bus.stat_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      bus.stat_ready = want_ready;
      if (!auto_done) eng_served = n_issued;
      if (man_req != man_served) begin
        bus.stat_done = 1'b1;
        man_served++;
      end else if (auto_done && n_issued > eng_served) begin
        bus.stat_done = 1'b1;
        eng_served++;
      end else begin
        bus.stat_done = 1'b0;
      end
    end
  end

  task automatic send(input logic [AB-1:0] a, input logic [LB-1:0] l, input bit c, input bit check_lat);
    bit ok;
    ok = 1'b0;
    @(posedge aclk);
    #1;
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_ctl   = c;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    bus.req_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL req_accept_timeout: got no req_ready, want accept");
    end
    if (check_lat) begin
      @(negedge aclk);
      chk("lat_calc_valid", 64'(bus.ctrl_valid), 64'd0);
      @(negedge aclk);
      chk("lat_issue_valid", 64'(bus.ctrl_valid), 64'd1);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk);
      if (!bus.busy && exp_q.size() == 0 && !bus.stat_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_idle_timeout: got busy=%0b pending=%0d, want idle", name, bus.busy, exp_q.size());
    end
    settle(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(bus.req_ready),  64'd1);
    chk({tag, "_ctrl_valid"}, 64'(bus.ctrl_valid), 64'd0);
    chk({tag, "_ctrl_addr"},  64'(bus.ctrl_addr),  64'd0);
    chk({tag, "_ctrl_len"},   64'(bus.ctrl_len),   64'd0);
    chk({tag, "_cmpl_done"},  64'(bus.cmpl_done),  64'd0);
    chk({tag, "_busy"},       64'(bus.busy),       64'd0);
    chk({tag, "_ctrl_ctl"},   64'(bus.ctrl_ctl),   64'd1);
  endtask

  initial begin
    int i0, c0;
    bit seen_v, seen_b;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_ctl   = 1'b0;
    want_ready    = 1'b1;
    auto_done     = 1'b0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("reset");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Multi-chunk request
    auto_done = 1'b1;
    c0 = n_cmpl;
    push_cmd(40'h1000, 24'h1000, 1'b0);
    push_cmd(40'h2000, 24'h1000, 1'b0);
    push_cmd(40'h3000, 24'h1000, 1'b1);
    send(40'h1000, 24'h3000, 1'b1, 1'b1);
    wait_idle("multi");
    chk("multi_cmpl_count", 64'(n_cmpl - c0), 64'd1);

    // Boundary straddle
    c0 = n_cmpl;
    push_cmd(40'h0FC0, 24'h40, 1'b0);
    push_cmd(40'h1000, 24'h40, 1'b1);
    send(40'h0FC0, 24'h80, 1'b1, 1'b1);
    wait_idle("straddle");
    chk("straddle_cmpl_count", 64'(n_cmpl - c0), 64'd1);

    // Zero length
    c0 = n_cmpl;
    i0 = n_issued;
    send(40'h2000, 24'h0, 1'b1, 1'b0);
    seen_v = 1'b0;
    seen_b = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      seen_v |= bus.ctrl_valid;
      seen_b |= bus.busy;
    end
    #1;
    chk("zero_ctrl_valid", 64'(seen_v), 64'd0);
    chk("zero_busy", 64'(seen_b), 64'd0);
    chk("zero_issued", 64'(n_issued - i0), 64'd0);
    chk("zero_cmpl", 64'(n_cmpl - c0), 64'd0);
    chk("zero_req_ready", 64'(bus.req_ready), 64'd1);

    // Credit limit with completions withheld
    @(negedge aclk);
    auto_done = 1'b0;
    c0 = n_cmpl;
    i0 = n_issued;
    push_cmd(40'h0000, 24'h1000, 1'b0);
    push_cmd(40'h1000, 24'h1000, 1'b0);
    push_cmd(40'h2000, 24'h1000, 1'b0);
    push_cmd(40'h3000, 24'h1000, 1'b1);
    send(40'h0, 24'h4000, 1'b1, 1'b1);
    settle(12);
    chk("credit_issued_2", 64'(n_issued - i0), 64'd2);
    chk("credit_valid_low", 64'(bus.ctrl_valid), 64'd0);
    chk("credit_busy", 64'(bus.busy), 64'd1);
    man_req++;
    settle(8);
    chk("credit_issued_3", 64'(n_issued - i0), 64'd3);
    want_ready = 1'b0;
    man_req++;
    settle(6);
    chk("credit_freed_valid", 64'(bus.ctrl_valid), 64'd1);
    chk("credit_stalled_issued", 64'(n_issued - i0), 64'd3);
    // Issue and stat_done land on the same edge with one outstanding.
    want_ready = 1'b1;
    man_req++;
    settle(6);
    chk("simul_issued_4", 64'(n_issued - i0), 64'd4);
    chk("simul_busy_one_left", 64'(bus.busy), 64'd1);
    chk("simul_no_cmpl_yet", 64'(n_cmpl - c0), 64'd0);
    man_req++;
    settle(4);
    chk("simul_busy_drained", 64'(bus.busy), 64'd0);
    chk("credit_cmpl_count", 64'(n_cmpl - c0), 64'd1);

    // Back-to-back A (ctl=0) and B (ctl=1)
    auto_done = 1'b1;
    c0 = n_cmpl;
    push_cmd(40'h5000, 24'h1000, 1'b0);
    push_cmd(40'h8F80, 24'h80, 1'b0);
    push_cmd(40'h9000, 24'h80, 1'b1);
    send(40'h5000, 24'h1000, 1'b0, 1'b0);
    send(40'h8F80, 24'h100, 1'b1, 1'b0);
    wait_idle("order");
    chk("order_cmpl_count", 64'(n_cmpl - c0), 64'd1);

    // Reset while chunk 2 of 3 waits in ISSUE
    auto_done = 1'b0;
    c0 = n_cmpl;
    i0 = n_issued;
    push_cmd(40'h1000, 24'h1000, 1'b0);
    push_cmd(40'h2000, 24'h1000, 1'b0);
    push_cmd(40'h3000, 24'h1000, 1'b1);
    send(40'h1000, 24'h3000, 1'b1, 1'b1);
    want_ready = 1'b0;
    settle(4);
    chk("rst_pre_issued", 64'(n_issued - i0), 64'd1);
    chk("rst_pre_valid", 64'(bus.ctrl_valid), 64'd1);
    chk("rst_pre_addr", 64'(bus.ctrl_addr), 64'h2000);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("midrst");
    @(posedge aclk);
    #1;
    aresetn    = 1'b1;
    want_ready = 1'b1;
    @(negedge aclk);
    auto_done = 1'b1;
    push_cmd(40'h1000, 24'h1000, 1'b0);
    push_cmd(40'h2000, 24'h1000, 1'b0);
    push_cmd(40'h3000, 24'h1000, 1'b1);
    send(40'h1000, 24'h3000, 1'b1, 1'b1);
    wait_idle("post_rst");
    chk("post_rst_cmpl_count", 64'(n_cmpl - c0), 64'd1);

`ifdef CDMA_SPLIT_STATS_EN
    chk("stat_reqs", 64'(stat_reqs), 64'd1);
    chk("stat_chunks", 64'(stat_chunks), 64'd3);
`endif

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("total_cmpl", 64'(n_cmpl), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish before limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdma_wr_req_split.md
# cdma_wr_req_split

Command front-end for the aligned CDMA write engine. It accepts arbitrary-length aligned write requests and splits each one into sub-commands that never cross a CHUNK_BYTES-aligned address boundary. It issues the sub-commands on the engine's ctrl/stat handshake, tracks outstanding sub-commands against a credit limit, and emits one completion pulse per request.

## Interface
- DATA_BITS, AXI_DATA_BITS: data bus width; sets alignment granule DATA_BYTES = DATA_BITS/8
- ADDR_BITS, AXI_ADDR_BITS: address width
- CHUNK_BYTES, 4096: split granule; power of two, ≥ DATA_BYTES
- MAX_OUTSTANDING, 8: maximum sub-commands issued but not yet completed
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  ADDR_BITS  start byte address; DATA_BYTES-aligned
- req_len  in  LEN_BITS  byte length; multiple of DATA_BYTES
- req_ctl  in  1  request wants a completion pulse
- cmpl_done  out  1  one-cycle pulse when the last sub-command of a req_ctl=1 request completes
- busy  out  1  FSM not IDLE, or outstanding count ≠ 0
- ctrl_valid  out  1  sub-command valid to engine
- stat_ready  in  1  engine ready; transfer on ctrl_valid & stat_ready
- ctrl_addr  out  ADDR_BITS  sub-command address
- ctrl_len  out  LEN_BITS  sub-command length in bytes
- ctrl_ctl  out  1  constant 1, so the engine reports every sub-command done
- stat_done  in  1  engine completion pulse, one per sub-command, in issue order

## Operation
- FSM states: IDLE, CALC, ISSUE.
- **IDLE**
  - req_ready=1.
  - On accept with req_len≠0: latch addr, remaining=req_len and ctl; go to CALC.
  - On accept with req_len=0: request is consumed; nothing is issued, no cmpl_done; stay in IDLE.
- **CALC** (one cycle)
  - room = CHUNK_BYTES − (addr mod CHUNK_BYTES).
  - chunk = min(remaining, room).
  - last = (remaining == chunk).
  - Register ctrl_addr=addr and ctrl_len=chunk; go to ISSUE.
- **ISSUE**
  - ctrl_valid=1 while outstanding < MAX_OUTSTANDING; otherwise ctrl_valid=0.
  - On handshake: addr += chunk; remaining −= chunk; outstanding += 1; push flag (ctl & last) into the completion queue.
  - After the handshake: if last, go to IDLE; else go to CALC.
- **Completion**
  - On stat_done: outstanding −= 1; pop the head flag.
  - cmpl_done is registered as stat_done & head flag.
  - If issue and stat_done occur in the same cycle, outstanding is unchanged; the queue pushes and pops simultaneously.
- A new request may be accepted while earlier sub-commands are still outstanding. Completions stay ordered because the queue is FIFO.
- stat_done with an empty queue is a protocol violation. It is ignored and outstanding does not underflow.
- Arithmetic: room is computed at width log2(CHUNK_BYTES)+1. Address increment wraps modulo 2^ADDR_BITS. remaining never goes negative.

## Timing
- Reset values:
  - req_ready=1
  - ctrl_valid=0
  - ctrl_addr=0
  - ctrl_len=0
  - cmpl_done=0
  - busy=0
  - ctrl_ctl=1
  - outstanding=0
  - queue empty
- Accept to first ctrl_valid: 2 cycles (accept edge → CALC → ISSUE).
- Sub-command throughput: at most one every 2 cycles.
- ctrl_addr, ctrl_len and ctrl_valid hold stable until the handshake; ctrl_valid never drops without a handshake except at the credit limit.
- stat_done → cmpl_done: 1 cycle.
- Reset mid-operation returns to the reset state on the next edge. Engine-side outstanding completions are discarded.

## Configuration
- CDMA_SPLIT_STATS_EN defined:
  - Adds output stat_reqs[31:0], counting accepted requests including zero-length ones.
  - Adds output stat_chunks[31:0], counting issued sub-commands.
  - Both wrap modulo 2^32 and reset to 0.
- CDMA_SPLIT_STATS_EN undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- The shared package iwTypes supplies LEN_BITS, AXI_DATA_BITS and AXI_ADDR_BITS. The FSM state enum goes into the same package as cdma_split_state_t.
- The only sub-module is Q_srl: depth MAX_OUTSTANDING, width 1, used as the completion-flag queue.
  - Its i_r gates issue alongside the outstanding credit.
  - Its o_r is driven by stat_done.

## Test plan
All scenarios use DATA_BITS=512 and CHUNK_BYTES=4096.
- **Multi-chunk request:** addr 0x1000, len 0x3000, ctl=1, engine always ready.
  - Expect sub-commands (0x1000,0x1000), (0x2000,0x1000), (0x3000,0x1000).
  - Expect exactly one cmpl_done, one cycle after the third stat_done.
- **Boundary straddle:** addr 0x0FC0, len 0x80 → (0x0FC0,0x40), (0x1000,0x40).
- **Zero length:** len 0, ctl=1 → req accepted; no ctrl_valid, no cmpl_done; busy stays 0.
- **Credit limit:** MAX_OUTSTANDING=2, stat_done withheld, addr 0, len 0x4000.
  - Expect only 2 sub-commands issued.
  - After one stat_done, the third issues.
- **Simultaneous events and ordering:**
  - stat_done in the same cycle as an issue at outstanding=1 leaves outstanding at 1.
  - With back-to-back requests A (ctl=0) and B (ctl=1), cmpl_done fires only on B's last completion.
- **Reset mid-operation:** assert aresetn=0 during ISSUE of chunk 2 of 3 → all outputs return to reset values; a new request then behaves as in the multi-chunk scenario.
